// File: rtl/mcp320x_spi_scan.sv
// mcp320x_spi_scan: frame-paced SPI master for MCP3202/MCP3204/MCP3208 12-bit ADCs.
// Each frame tick converts channels 0..NUM_CH-1 back-to-back, one chip-select window
// per channel. Each result is emitted with its channel tag and a one-cycle valid pulse.
module mcp320x_spi_scan #(
  parameter int unsigned FCLK   = 100_000_000,
  parameter int unsigned FSCK   = 500_000,
  parameter int unsigned FS     = 500,
  parameter int unsigned DEVICE = 3202,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SGL    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        miso,
  output logic        mosi,
  output logic        sck,
  output logic        cs_n,
  output logic [11:0] data,
  output logic [2:0]  ch,
  output logic        dv,
  output logic        busy
);

  localparam int unsigned HALF   = FCLK / (2 * FSCK);
  localparam int unsigned CSH    = FCLK / 2_000_000 + 1;
  localparam int unsigned PERIOD = FCLK / FS;
  localparam int unsigned TOTAL  = (DEVICE == 3202) ? 17 : 19;
  // First SCK rise that carries result bit B11; B0 lands on rise TOTAL.
  localparam int unsigned FIRST  = TOTAL - 11;
  localparam int unsigned TMAX   = (HALF > CSH) ? HALF : CSH;
  localparam int unsigned TW     = $clog2(TMAX + 1);
  localparam int unsigned PW     = $clog2(PERIOD + 1);
  localparam int unsigned BUDGET = NUM_CH * (2 * HALF * (TOTAL + 1) + CSH);
  localparam logic        SGL_B  = (SGL != 0);

  // Parameter sanity checks, evaluated at elaboration.
  if (FSCK < 10_000 || FSCK > 900_000) begin : g_bad_fsck
    $error("mcp320x_spi_scan: FSCK must be 10_000..900_000");
  end
  if (DEVICE != 3202 && DEVICE != 3208) begin : g_bad_device
    $error("mcp320x_spi_scan: DEVICE must be 3202 or 3208");
  end
  if (NUM_CH < 1 || NUM_CH > ((DEVICE == 3202) ? 2 : 8)) begin : g_bad_num_ch
    $error("mcp320x_spi_scan: NUM_CH out of range for DEVICE");
  end
  if (BUDGET >= PERIOD) begin : g_bad_budget
    $error("mcp320x_spi_scan: channel scan does not fit in one frame period");
  end

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSckHi,
    StSckLo,
    StEnd,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [4:0]      edge_q, edge_d;
  logic [2:0]      idx_q, idx_d;
  logic [11:0]     shift_q, shift_d;
  logic [PW-1:0]   frame_q, frame_d;
  logic            frame_tick;
  logic            rise;

  logic            cs_n_q, cs_n_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic [11:0]     data_q, data_d;
  logic [2:0]      ch_q, ch_d;
  logic            dv_q, dv_d;
  logic            busy_q, busy_d;

  // Command bit k (1-based, MSB first) for channel idx; zero past the command.
  function automatic logic cmd_bit(input logic [2:0] idx, input logic [4:0] k);
    logic [4:0] cmd;
    if (DEVICE == 3202) begin
      cmd = {1'b1, SGL_B, idx[0], 1'b1, 1'b0};  // start, SGL, ODD/SIGN, MSBF
    end else begin
      cmd = {1'b1, SGL_B, idx};                  // start, SGL, D2, D1, D0
    end
    if (k >= 5'd1 && k <= 5'd5) begin
      return cmd[3'(5'd5 - k)];
    end
    return 1'b0;
  endfunction

  // Frame counter: runs 0..PERIOD-1 while enabled and ticks on the wrap; held at zero otherwise.
  always_comb begin
    frame_tick = en && (frame_q == PW'(PERIOD - 1));
    frame_d    = frame_q + 1'b1;
    if (!en || frame_tick) begin
      frame_d = '0;
    end
  end

  // Transaction FSM: next state and registered output values, set on state entry.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    edge_d  = edge_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    data_d  = data_q;
    ch_d    = ch_q;
    dv_d    = 1'b0;
    busy_d  = busy_q;
    rise    = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmr_d = '0;
        // Ticks can only land here with valid parameters; any other tick is ignored.
        if (frame_tick) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StSetup;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          edge_d  = '0;
          mosi_d  = cmd_bit(idx_d, 5'd1);
        end
      end
      StSetup: begin
        if (tmr_q == TW'(HALF - 1)) begin
          rise = 1'b1;
        end
      end
      StSckHi: begin
        if (tmr_q == TW'(HALF - 1)) begin
          state_d = StSckLo;
          tmr_d   = '0;
          sck_d   = 1'b0;
          mosi_d  = cmd_bit(idx_q, 5'(edge_q + 5'd1));
        end
      end
      StSckLo: begin
        if (tmr_q == TW'(HALF - 1)) begin
          if (edge_q == 5'(TOTAL)) begin
            state_d = StEnd;
            tmr_d   = '0;
            cs_n_d  = 1'b1;
            data_d  = shift_q;
            ch_d    = idx_q;
            dv_d    = 1'b1;
          end else begin
            rise = 1'b1;
          end
        end
      end
      StEnd: begin
        state_d = StGap;
        tmr_d   = '0;
      end
      StGap: begin
        if (tmr_q == TW'(CSH - 1)) begin
          tmr_d = '0;
          if (idx_q < 3'(NUM_CH - 1)) begin
            idx_d   = idx_q + 1'b1;
            state_d = StSetup;
            cs_n_d  = 1'b0;
            edge_d  = '0;
            mosi_d  = cmd_bit(idx_d, 5'd1);
          end else begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // SCK rising edge: count it and capture miso once result bits are on the line.
    if (rise) begin
      state_d = StSckHi;
      tmr_d   = '0;
      sck_d   = 1'b1;
      edge_d  = edge_q + 1'b1;
      if (edge_d >= 5'(FIRST)) begin
        shift_d = {shift_q[10:0], miso};
      end
    end
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      edge_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      frame_q <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      edge_q  <= edge_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
    end
  end

  assign cs_n = cs_n_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign data = data_q;
  assign ch   = ch_q;
  assign dv   = dv_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mcp320x_spi_scan.sv
// Bench for mcp320x_spi_scan: three configurations (MCP3202 x2 single-ended,
// MCP3208 x8 differential, MCP3204-style x4) run side by side from one clock.
// Per instance an ADC model serves miso, captures the command on mosi, pushes the
// expected (channel, data) when chip select falls and pops it on each dv pulse.
module tb_mcp320x_spi_scan;

  localparam int unsigned P_DEV    [3] = '{3202, 3208, 3208};
  localparam int unsigned P_NCH    [3] = '{2, 8, 4};
  localparam int unsigned P_SGL    [3] = '{1, 0, 1};
  localparam int unsigned P_FS     [3] = '{20_000, 5_000, 10_000};
  localparam int unsigned P_PERIOD [3] = '{5_000, 20_000, 10_000};
  localparam int unsigned P_TOT    [3] = '{17, 19, 19};
  localparam int unsigned HALF_CYC  = 55;  // 100 MHz / (2 * 900 kHz)
  localparam int unsigned CS_HI_CYC = 52;  // END cycle plus CSH = 51

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  en;
  logic [2:0]  miso = '0;
  logic [2:0]  mosi, sck, cs_n, dv, busy;
  logic [11:0] data [3];
  logic [2:0]  chv  [3];
  logic [1:0]  mode;  // instance 0 miso: 0 = table, 1 = held high, 2 = held low

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mcp320x_spi_scan #(
      .FCLK  (100_000_000),
      .FSCK  (900_000),
      .FS    (P_FS[g]),
      .DEVICE(P_DEV[g]),
      .NUM_CH(P_NCH[g]),
      .SGL   (P_SGL[g])
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en[g]),
      .miso (miso[g]),
      .mosi (mosi[g]),
      .sck  (sck[g]),
      .cs_n (cs_n[g]),
      .data (data[g]),
      .ch   (chv[g]),
      .dv   (dv[g]),
      .busy (busy[g])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] adc_val(input int g, input int c, input logic [1:0] m);
    if (g == 0) begin
      if (m == 2'd1) return 12'hFFF;
      if (m == 2'd2) return 12'h000;
      return (c == 0) ? 12'h7DC : 12'hA53;
    end
    return 12'h100 + 12'(c);
  endfunction

  // Expected mosi bits seen on rises 1..TOTAL, right-aligned.
  function automatic logic [19:0] exp_cmd(input int g, input int c);
    logic [2:0] cb;
    cb = 3'(c);
    if (g == 0) return {3'b000, 1'b1, 1'b1, cb[0], 1'b1, 13'd0};
    if (g == 1) return {1'b0, 1'b1, 1'b0, cb, 14'd0};
    return {1'b0, 1'b1, 1'b1, cb, 14'd0};
  endfunction

  // miso value the ADC presents for rise number nxt of the current transaction.
  function automatic logic adc_bit(input int g, input logic [1:0] m, input logic [11:0] v,
                                   input int nxt);
    if (g == 0 && m == 2'd1) return 1'b1;
    if (g == 0 && m == 2'd2) return 1'b0;
    if (nxt >= int'(P_TOT[g]) - 11 && nxt <= int'(P_TOT[g])) return v[P_TOT[g] - nxt];
    return 1'b0;
  endfunction

  logic        rst_s;
  logic [2:0]  en_s;
  // Inputs as the DUT saw them at the last active edge.
  always @(posedge clk) begin
    rst_s <= rst_n;
    en_s  <= en;
  end

  logic [14:0]  sb_q [3][$];
  int           rises  [3];
  int           cyc    [3];
  int           cs_hi  [3];
  int           exp_ch [3];
  int           dvn    [3];
  int unsigned  en_run [3];
  logic [19:0]  mos    [3];
  logic [11:0]  cur_val[3];
  logic [11:0]  last_d [3];
  logic [2:0]   last_c [3];
  logic [2:0]   sck_p, cs_p, busy_p, dv_p;

  // ADC models, protocol timing checks and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      string       pfx;
      logic [14:0] e;
      pfx = $sformatf("u%0d.", g);
      if (!rst_s) begin
        chk({pfx, "reset_out"},
            {cs_n[g], sck[g], mosi[g], data[g], chv[g], dv[g], busy[g]}, {1'b1, 19'd0});
        sb_q[g].delete();
        exp_ch[g] = 0;
        dvn[g]    = 0;
        en_run[g] = 0;
        rises[g]  = 0;
        cs_hi[g]  = 0;
        last_d[g] = '0;
        last_c[g] = '0;
        miso[g]   = 1'b0;
      end else begin
        cyc[g]++;
        if (en_s[g]) en_run[g]++;
        else en_run[g] = 0;
        if (cs_n[g]) cs_hi[g]++;

        if (busy[g] && !busy_p[g]) begin
          chk({pfx, "frame_phase"}, en_run[g] % P_PERIOD[g], 0);
          chk({pfx, "frame_en"}, en_run[g] > 0, 1);
          chk({pfx, "frame_ch0"}, exp_ch[g], 0);
          dvn[g] = 0;
        end
        if (!busy[g] && busy_p[g]) begin
          chk({pfx, "frame_dv_count"}, dvn[g], P_NCH[g]);
        end

        if (!cs_n[g] && cs_p[g]) begin
          chk({pfx, "cs_in_frame"}, busy[g], 1);
          if (dvn[g] > 0) chk({pfx, "cs_gap"}, cs_hi[g], CS_HI_CYC);
          cur_val[g] = adc_val(g, exp_ch[g], mode);
          sb_q[g].push_back({exp_ch[g][2:0], cur_val[g]});
          rises[g] = 0;
          mos[g]   = '0;
          cyc[g]   = 0;
          miso[g]  = adc_bit(g, mode, cur_val[g], 1);
        end

        if (sck[g] && !sck_p[g]) begin
          rises[g]++;
          chk({pfx, "sck_cs_low"}, cs_n[g], 0);
          if (rises[g] == 1) chk({pfx, "tsucs"}, cyc[g], HALF_CYC);
          else chk({pfx, "sck_period"}, cyc[g], 2 * HALF_CYC);
          mos[g] = {mos[g][18:0], mosi[g]};
          cyc[g] = 0;
        end
        if (!sck[g] && sck_p[g]) begin
          chk({pfx, "sck_high"}, cyc[g], HALF_CYC);
          miso[g] = adc_bit(g, mode, cur_val[g], rises[g] + 1);
        end

        if (cs_n[g] && !cs_p[g]) begin
          chk({pfx, "rises"}, rises[g], P_TOT[g]);
          chk({pfx, "cmd"}, mos[g], exp_cmd(g, exp_ch[g]));
          exp_ch[g] = (exp_ch[g] + 1) % int'(P_NCH[g]);
          cs_hi[g]  = 1;
        end

        if (dv[g]) begin
          chk({pfx, "dv_width"}, dv_p[g], 0);
          chk({pfx, "dv_cs_high"}, cs_n[g], 1);
          chk({pfx, "dv_pending"}, sb_q[g].size() > 0, 1);
          if (sb_q[g].size() > 0) begin
            e = sb_q[g].pop_front();
            chk({pfx, "dv_ch"}, chv[g], e[14:12]);
            chk({pfx, "dv_data"}, data[g], e[11:0]);
          end
          dvn[g]++;
          last_d[g] = data[g];
          last_c[g] = chv[g];
        end else begin
          chk({pfx, "hold"}, {chv[g], data[g]}, {last_c[g], last_d[g]});
        end
      end
      sck_p[g]  = sck[g];
      cs_p[g]   = cs_n[g];
      busy_p[g] = busy[g];
      dv_p[g]   = dv[g];
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic found;
    rst_n = 1'b0;
    en    = '0;
    mode  = 2'd0;
    cyc_wait(5);
    rst_n = 1'b1;
    en    = 3'b111;
    // Instance 0 frames start every 5000 cycles and finish about 3960 cycles later.
    cyc_wait(14_500);
    mode = 2'd1;
    cyc_wait(5_000);
    mode = 2'd2;
    cyc_wait(5_000);
    mode = 2'd0;
    cyc_wait(1_000);
    en[0] = 1'b0;  // during ch0 of instance 0's frame
    cyc_wait(5_500);
    en[0] = 1'b1;
    cyc_wait(4_000);
    found = 1'b0;
    for (int i = 0; i < 20_000 && !found; i++) begin
      @(posedge clk);
      if (rises[0] == 7 && sck[0]) found = 1'b1;
    end
    #1;
    chk("u0.rise7_seen", found, 1);
    rst_n = 1'b0;
    cyc_wait(5);
    rst_n = 1'b1;
    cyc_wait(40_000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mcp320x_spi_scan.md
Name: mcp320x_spi_scan

Overview:
- Parametrised SPI master for the Microchip MCP3202, MCP3204 and MCP3208 12-bit ADCs; successor to the fixed 2-channel, 500 sps MCP3202 interface.
- Generates a frame tick at FS Hz. On each frame it converts channels 0..NUM_CH-1 back-to-back, one CS-framed transaction per channel.
- Each result is presented with its channel tag and a one-cycle valid pulse to the downstream ECG filter chain.

Parameters:
- FCLK, 100_000_000, system clock frequency in Hz (10 MHz to 200 MHz).
- FSCK, 500_000, SCK frequency in Hz; must be 10_000 to 900_000, else elaboration error.
- FS, 500, frames per second, i.e. samples per channel per second.
- DEVICE, 3202, 3202 or 3208; 3204 parts use 3208.
- NUM_CH, 2, channels scanned per frame; 1..2 for 3202, 1..8 for 3208.
- SGL, 1, 1 = single-ended, 0 = differential; the channel index selects the pair.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- en  in  1  frame enable
- miso  in  1  ADC DOUT
- mosi  out  1  ADC DIN
- sck  out  1  SPI clock, idle low (mode 0,0)
- cs_n  out  1  ADC chip select, active low
- data  out  12  last conversion result
- ch  out  3  channel of data
- dv  out  1  one-cycle data-valid pulse
- busy  out  1  high from frame start to end of last channel's gap

Behaviour:
- Reset: rst_n is synchronous and active-low.
- While rst_n is low, outputs hold these values: cs_n=1, sck=0, mosi=0, data=0, ch=0, dv=0, busy=0.
- While rst_n is low, all counters clear and the FSM goes to IDLE.
- Reset asserted mid-conversion aborts the conversion on the next clk edge; no dv is produced for it.
- Derived constants:
  - HALF = FCLK/(2*FSCK) clocks.
  - CSH = FCLK/2_000_000 + 1 clocks, which is at least 500 ns.
  - PERIOD = FCLK/FS clocks.
  - TOTAL = 17 for DEVICE 3202, 19 for DEVICE 3208.
  - Elaboration error if NUM_CH*(2*HALF*(TOTAL+1)+CSH) >= PERIOD.
- Frame counter:
  - Counts 0..PERIOD-1 while en=1 and wraps; a frame tick fires on the wrap.
  - en=0 holds the counter at 0; a frame already in progress completes all channels.
  - The first frame therefore starts PERIOD cycles after en=1 with reset released.
- Command bits, sent MSB first:
  - DEVICE 3202: 1, SGL, ch[0], 1 (MSBF); 4 bits.
  - DEVICE 3208: 1, SGL, ch[2], ch[1], ch[0]; 5 bits.
  - mosi = 0 after the last command bit.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, END, GAP.
- IDLE:
  - On frame tick: channel index := 0, busy := 1, go to SETUP.
- SETUP:
  - cs_n=0, sck=0, mosi = command bit 1; hold HALF clocks.
  - This guarantees TSUCS >= 100 ns. Go to SCK_HI.
- SCK_HI:
  - sck=1 for HALF clocks; the rise is counted as edge k (1..TOTAL).
  - miso is sampled on the clk where sck rises.
  - For k in TOTAL-11..TOTAL, shift miso into the result register MSB first.
  - Go to SCK_LO.
- SCK_LO:
  - sck=0 for HALF clocks; mosi updates to command bit k+1 on entry.
  - If k==TOTAL go to END, else go to SCK_HI.
- END:
  - cs_n := 1.
  - Same cycle: data := result, ch := channel index, dv := 1 for exactly one clk.
  - Go to GAP.
- GAP:
  - cs_n=1 for CSH clocks.
  - If channel index < NUM_CH-1: increment index, go to SETUP.
  - Otherwise: busy := 0, go to IDLE.
- SCK period is exactly 2*HALF clocks; TOTAL rising edges occur per cs_n-low window.
- A frame tick arriving while busy=1 cannot occur with valid parameters and is ignored.
- data and ch hold their values between dv pulses.

Test Plan:
- Scan, 3202: defaults (HALF=100); ADC model returns 0x7DC on ch0 and 0xA53 on ch1 -> dv pulses (ch=0, 0x7DC) then (ch=1, 0xA53); frames 2,000,000 ns apart; mosi command 1,1,0,1 then 1,1,1,1.
- Timing: same run -> SCK period 2000 ns; TSUCS >= 100 ns; cs_n high >= 500 ns between transactions; exactly 17 sck rises per cs_n-low window; dv width 10 ns.
- Scan, 3208 differential: DEVICE=3208, NUM_CH=8, SGL=0, model returns 0x100+ch -> 19 rises per transaction; ch5 command 1,0,1,0,1; dv tags 0..7 in order with data 0x100..0x107.
- Extremes: miso held 1 -> data 0xFFF; miso held 0 -> data 0x000; MCP3204 configuration (DEVICE=3208, NUM_CH=4) -> ch wraps 3 -> 0 on the next frame.
- Enable: en dropped during ch0 of a frame -> ch1 still converts, busy falls, then no cs_n activity; en raised again -> next frame starts PERIOD cycles later.
- Reset mid-op: rst_n low after the 7th sck rise -> next clk: cs_n=1, sck=0, dv=0, busy=0; no dv for the aborted conversion; normal scan resumes after release.
